// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader: reads a contiguous word range from on-chip memory port s2 and streams it out with SOP/EOP.
// Latency: start at T -> first read at T+1 -> first st_valid at T+3; 1 word/clk in steady state.
// Backpressure: a read is issued only against a free FIFO credit, so st_ready low stalls reads after FIFO_DEPTH words.
//
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   start, base_addr, word_count, abort  transfer control (start sampled only when idle)
//   busy, done                           transfer status (done is a 1-cycle pulse)
//   mem_*                                Avalon-MM read master, fixed read latency of 1 clk
//   st_*                                 Avalon-ST source, show-ahead from the output FIFO

// Small show-ahead FIFO: head_dat_o is the oldest entry whenever empty_o is low.
// Flush clears all entries at the next edge and wins over a simultaneous push.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage needs no reset: an entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
endmodule

module onchip_mem_stream_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 60000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_sop,
    output logic                st_eop
);
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic                inflight_q;
    logic                sop_tag_q;
    logic                eop_tag_q;
    logic                done_q, done_d;

    logic                issue;
    logic                last_issue;
    logic                flush;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [CW-1:0]       fifo_count;
    logic [DATA_W+1:0]   fifo_head;

    // A credit is a FIFO slot not yet owned by a stored word or the word in flight.
    // fifo_count is the registered count, so a pop this cycle frees its credit only next cycle.
    assign issue = (state_q == S_RUN) && !abort && (issued_q < count_q) &&
                   ((fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    assign last_issue = issue && (issued_q == (count_q - CNT_ONE));

    assign pop = st_valid && st_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        flush    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start beats a coincident abort here simply because abort is not looked at.
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = base_addr;
                        count_d  = word_count;
                        issued_d = '0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (issue) begin
                    issued_d = issued_q + CNT_ONE;
                    addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
                    if (last_issue) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (!inflight_q && ((fifo_count - CW'(pop)) == '0)) begin
                    // Finish in the same cycle the last beat leaves, so done follows EOP by one clock.
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            sop_tag_q  <= 1'b0;
            eop_tag_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            // Abort suppresses issue, so nothing is left in flight after it.
            inflight_q <= issue;
            sop_tag_q  <= issue && (issued_q == '0);
            eop_tag_q  <= last_issue;
            done_q     <= done_d;
        end
    end

    // SOP/EOP travel with the word through the FIFO so they stay aligned under backpressure.
    fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_i    (flush),
        .push_i     (inflight_q),
        .push_dat_i ({eop_tag_q, sop_tag_q, mem_readdata}),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign st_valid = !fifo_empty;
    assign st_data  = fifo_head[DATA_W-1:0];
    assign st_sop   = st_valid && fifo_head[DATA_W];
    assign st_eop   = st_valid && fifo_head[DATA_W+1];

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(inflight_q && fifo_full && !pop));
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
module tb_onchip_mem_stream_reader;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int MEM_WORDS  = 60000;
    localparam int FIFO_DEPTH = 8;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     word_count;
    logic                abort;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;
    logic                st_sop;
    logic                st_eop;

    onchip_mem_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory holds mem[i] = i; a non-selected cycle returns garbage so a mistimed capture shows up.
    always @(posedge clk) begin
        mem_readdata <= mem_chipselect ? 32'(mem_address) : 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    beat_t exp_q[$];
    int    exp_addr_q[$];
    logic  busy_m = 1'b0;
    logic  done_m = 1'b0;
    int    cs_cnt = 0;
    int    beat_cnt = 0;

    // Event logs used by the literal expectations
    int         cs_log[$];
    int         cs_cyc[$];
    int         beat_log[$];
    int         beat_cyc[$];
    logic [1:0] flag_log[$];
    int         done_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Runs at the falling edge: checks this cycle's outputs, then advances the model with this cycle's inputs.
    task automatic model_step();
        logic  eop_beat;
        beat_t b;
        int    a;
        if (!reset_n) begin
            busy_m = 1'b0;
            done_m = 1'b0;
            exp_q.delete();
            exp_addr_q.delete();
            cs_cnt = 0;
            beat_cnt = 0;
            return;
        end
        eop_beat = 1'b0;
        chk("busy", busy, busy_m);
        chk("done", done, done_m);
        chk("mem_write", mem_write, 0);
        chk("mem_byteenable", mem_byteenable, 4'hF);
        chk("mem_clken", mem_clken, 1);
        if (done) done_log.push_back(cyc);
        if (busy_m && abort) chk("cs_on_abort", mem_chipselect, 0);
        if (mem_chipselect) begin
            cs_log.push_back(int'(mem_address));
            cs_cyc.push_back(cyc);
            chk("addr_range", mem_address < MEM_WORDS, 1);
            if (exp_addr_q.size() == 0) begin
                chk("cs_unexpected", mem_chipselect, 0);
            end else begin
                chk("cs_addr", mem_address, exp_addr_q.pop_front());
                chk("cs_credit", (cs_cnt - beat_cnt) < FIFO_DEPTH, 1);
            end
            cs_cnt++;
        end
        if (st_valid) begin
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", st_valid, 0);
            end else begin
                chk("st_data", st_data, exp_q[0].data);
                chk("st_sop", st_sop, exp_q[0].sop);
                chk("st_eop", st_eop, exp_q[0].eop);
                if (st_ready) begin
                    b = exp_q.pop_front();
                    beat_cnt++;
                    beat_log.push_back(int'(st_data));
                    beat_cyc.push_back(cyc);
                    flag_log.push_back({st_sop, st_eop});
                    eop_beat = b.eop;
                end
            end
        end
        done_m = 1'b0;
        if (busy_m && abort) begin
            done_m = 1'b1;
            busy_m = 1'b0;
            exp_q.delete();
            exp_addr_q.delete();
            cs_cnt = 0;
            beat_cnt = 0;
        end else if (busy_m && eop_beat) begin
            done_m = 1'b1;
            busy_m = 1'b0;
        end else if (!busy_m && start) begin
            if (word_count == 0) begin
                done_m = 1'b1;
            end else begin
                busy_m = 1'b1;
                cs_cnt = 0;
                beat_cnt = 0;
                for (int k = 0; k < int'(word_count); k++) begin
                    a = (int'(base_addr) + k) % MEM_WORDS;
                    exp_addr_q.push_back(a);
                    b.data = 32'(a);
                    b.sop  = (k == 0);
                    b.eop  = (k == int'(word_count) - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_start(input int base, input int cnt, output int sc);
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W+1)'(cnt);
        sc         = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int i;
        i = 0;
        while (done_log.size() <= n0 && i < budget) begin
            tick();
            i++;
        end
        if (done_log.size() <= n0) chk("done_timeout", done_log.size(), n0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int sc, n0, b0, c0, c_pre, acyc, g;
        int t2_addr [4];
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        abort      = 1'b0;
        st_ready   = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", st_valid, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_sop_eop", {st_sop, st_eop}, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();

        // 1: base 0x10, count 4, ready held high
        n0 = done_log.size(); b0 = beat_log.size(); c0 = cs_log.size();
        do_start(16'h0010, 4, sc);
        wait_done(n0, 40);
        chk("t1_first_cs_cycle", cs_cyc[c0], sc + 1);
        chk("t1_beats", beat_log.size() - b0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_data", beat_log[b0 + k], 32'h10 + k);
            chk("t1_beat_cycle", beat_cyc[b0 + k], sc + 3 + k);
        end
        chk("t1_sop_first", flag_log[b0], 2'b10);
        chk("t1_eop_last", flag_log[b0 + 3], 2'b01);
        chk("t1_done_cycle", done_log[n0], sc + 7);
        tick();

        // 2: address wrap at the top of memory
        t2_addr = '{59998, 59999, 0, 1};
        n0 = done_log.size(); c0 = cs_log.size();
        do_start(59998, 4, sc);
        wait_done(n0, 40);
        chk("t2_cs_count", cs_log.size() - c0, 4);
        for (int k = 0; k < 4; k++) chk("t2_addr", cs_log[c0 + k], t2_addr[k]);
        tick();

        // 3: ready held low -> exactly FIFO_DEPTH reads, then release
        n0 = done_log.size(); b0 = beat_log.size(); c0 = cs_log.size();
        st_ready = 1'b0;
        do_start(100, 32, sc);
        repeat (30) tick();
        chk("t3_stalled_cs", cs_log.size() - c0, 8);
        chk("t3_valid_held", st_valid, 1);
        chk("t3_head", st_data, 100);
        st_ready = 1'b1;
        wait_done(n0, 200);
        chk("t3_beats", beat_log.size() - b0, 32);
        for (int k = 0; k < 32; k++) chk("t3_order", beat_log[b0 + k], 100 + k);
        tick();

        // 4: zero-length transfer
        n0 = done_log.size(); b0 = beat_log.size(); c0 = cs_log.size();
        do_start(5, 0, sc);
        wait_done(n0, 10);
        repeat (4) tick();
        chk("t4_done_cycle", done_log[n0], sc + 1);
        chk("t4_done_count", done_log.size() - n0, 1);
        chk("t4_no_cs", cs_log.size() - c0, 0);
        chk("t4_no_beats", beat_log.size() - b0, 0);

        // 5: single word, second start while busy is ignored
        n0 = done_log.size(); b0 = beat_log.size(); c0 = cs_log.size();
        do_start(200, 1, sc);
        do_start(300, 3, g);
        wait_done(n0, 20);
        repeat (6) tick();
        chk("t5_beats", beat_log.size() - b0, 1);
        chk("t5_data", beat_log[b0], 200);
        chk("t5_sop_eop", flag_log[b0], 2'b11);
        chk("t5_cs_count", cs_log.size() - c0, 1);
        chk("t5_done_count", done_log.size() - n0, 1);

        // 6: abort after 5 words under random backpressure
        n0 = done_log.size(); b0 = beat_log.size();
        do_start(1000, 20, sc);
        g = 0;
        while (beat_log.size() - b0 < 5 && g < 400) begin
            st_ready = 1'($urandom_range(0, 1));
            tick();
            g++;
        end
        chk("t6_five_beats", beat_log.size() - b0, 5);
        st_ready = 1'b0;
        abort    = 1'b1;
        c_pre    = cs_log.size();
        acyc     = cyc;
        tick();
        abort = 1'b0;
        chk("t6_flushed_valid", st_valid, 0);
        repeat (8) begin
            st_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("t6_cs_stopped", cs_log.size(), c_pre);
        chk("t6_done_count", done_log.size() - n0, 1);
        chk("t6_done_cycle", done_log[n0], acyc + 1);
        chk("t6_beats_total", beat_log.size() - b0, 5);
        for (int k = 0; k < 5; k++) chk("t6_no_eop", flag_log[b0 + k][0], 0);
        st_ready = 1'b1;
        n0 = done_log.size(); b0 = beat_log.size();
        do_start(42, 3, sc);
        wait_done(n0, 30);
        chk("t6_restart_beats", beat_log.size() - b0, 3);
        for (int k = 0; k < 3; k++) chk("t6_restart_data", beat_log[b0 + k], 42 + k);
        tick();

        // 7: asynchronous reset mid-transfer
        do_start(500, 16, sc);
        repeat (5) tick();
        n0 = done_log.size();
        reset_n = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_valid", st_valid, 0);
        chk("t7_cs", mem_chipselect, 0);
        chk("t7_addr", mem_address, 0);
        chk("t7_done", done, 0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("t7_no_done", done_log.size(), n0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
